bist_datapath: RTL and testbench

Address/data/compare datapath of the memory BIST, directly downstream of the BIST `control` FSM. It turns the controller's strobes (`enable`, `up_down`, `rst_adr`, `data_bit`, `wr_en`, `read_en`) into memory address, write-data and read/write strobes. It returns the `c_out` terminal-count pulse that advances the controller between march elements. It also checks read data against the expected background and keeps the fail log.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_adr_cnt.sv | 40 ++++
 rtl/bist_datapath.sv | 112 +++++++++++
 tb/tb_bist_datapath.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared memory-BIST definitions: default widths, fail-counter limits and the
// sweep terminal-address helper used by the datapath and the control FSM.
package bist_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;

  localparam int                    FAIL_CNT_W   = 8;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = 8'd255;

  // Terminal address of a sweep; the start address is term_adr(!up_down, aw).
  function automatic logic [31:0] term_adr(input logic up_down, input int unsigned aw);
    return up_down ? ((32'd1 << aw) - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/bist_adr_cnt.sv
// BIST address counter: start-address load, modulo up/down count and a
// registered one-cycle terminal-count pulse.
module bist_adr_cnt
  import bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up_down,
  input  logic              rst_adr,
  output logic [ADDR_W-1:0] adr,
  output logic              c_out
);

  logic [ADDR_W-1:0] term;
  logic [ADDR_W-1:0] start;
  logic              wrap;

  assign term  = ADDR_W'(term_adr(up_down, ADDR_W));
  assign start = ADDR_W'(term_adr(!up_down, ADDR_W));
  // A start-address load wins over a terminal step, so no pulse is raised then.
  assign wrap  = enable && !rst_adr && (adr == term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr   <= '0;
      c_out <= 1'b0;
    end else begin
      c_out <= wrap;
      if (rst_adr || wrap) begin
        adr <= start;
      end else if (enable) begin
        adr <= up_down ? adr + ADDR_W'(1) : adr - ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/bist_datapath.sv
// Memory-BIST address/data/compare datapath with read-compare pipeline and fail log.
// Define BIST_FAIL_LOG_EN to implement fail_adr/fail_cnt; otherwise they read as 0.
module bist_datapath
  import bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  rst_adr,
  input  logic                  data_bit,
  input  logic                  wr_en,
  input  logic                  read_en,
  input  logic                  clr,
  output logic                  c_out,
  output logic [ADDR_W-1:0]     mem_adr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err,
  output logic                  fail,
  output logic [ADDR_W-1:0]     fail_adr,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  logic [ADDR_W-1:0] adr;

  bist_adr_cnt #(
    .ADDR_W(ADDR_W)
  ) u_adr_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .up_down(up_down),
    .rst_adr(rst_adr),
    .adr    (adr),
    .c_out  (c_out)
  );

  assign mem_adr   = adr;
  assign mem_wdata = {DATA_W{data_bit}};
  assign mem_we    = wr_en;
  assign mem_re    = read_en;

  // ---- Stage p0..p(RD_LAT-1): expected word travels with the read until data returns
  logic              vld_p [RD_LAT];
  logic [DATA_W-1:0] exp_p [RD_LAT];
  logic              miss;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= read_en;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_p[0] <= mem_wdata;
    for (int i = 1; i < RD_LAT; i++) exp_p[i] <= exp_p[i-1];
  end

  // ---- Compare stage: read data meets the oldest pipeline entry
  assign miss = vld_p[RD_LAT-1] && (mem_rdata != exp_p[RD_LAT-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err  <= 1'b0;
      fail <= 1'b0;
    end else begin
      err  <= miss;
      fail <= clr ? miss : (fail | miss);
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] adr_p [RD_LAT];

  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] cnt);
    return (cnt == FAIL_CNT_MAX) ? cnt : cnt + FAIL_CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    adr_p[0] <= adr;
    for (int i = 1; i < RD_LAT; i++) adr_p[i] <= adr_p[i-1];
  end

  // A clear coincident with a mismatch restarts the log with that mismatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_adr <= '0;
      fail_cnt <= '0;
    end else if (clr) begin
      fail_adr <= miss ? adr_p[RD_LAT-1] : '0;
      fail_cnt <= miss ? FAIL_CNT_W'(1) : '0;
    end else if (miss) begin
      if (!fail) fail_adr <= adr_p[RD_LAT-1];
      fail_cnt <= sat_inc(fail_cnt);
    end
  end
`else
  assign fail_adr = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_bist_datapath.sv
// Self-checking bench for bist_datapath: reference counter, memory model with
// stuck words, and an expected-err scoreboard filled when reads are driven.
module tb_bist_datapath;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef BIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, enable, up_down, rst_adr, data_bit, wr_en, read_en, clr;
  logic              c_out, mem_we, mem_re, err, fail;
  logic [ADDR_W-1:0] mem_adr, fail_adr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [7:0]        fail_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bist_datapath #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .up_down  (up_down),
    .rst_adr  (rst_adr),
    .data_bit (data_bit),
    .wr_en    (wr_en),
    .read_en  (read_en),
    .clr      (clr),
    .c_out    (c_out),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .err      (err),
    .fail     (fail),
    .fail_adr (fail_adr),
    .fail_cnt (fail_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: writes from DUT strobes, reads return after RD_LAT edges.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              stuck   [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  assign mem_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_wdata;
    rd_pipe[0] <= stuck[mem_adr] ? {DATA_W{1'b1}} : mem[mem_adr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic              miss;
  } sb_t;
  sb_t sb_q[$];

  // Reference counter and err expectation, evaluated every rising edge.
  logic [ADDR_W-1:0] m_adr;
  logic              m_cout, m_err;
  logic              dl [RD_LAT];
  logic              s_en, s_ud, s_ra, s_re, s_due;
  sb_t               s_e;
  int                cout_seen;

  always @(posedge clk) begin
    s_en  = enable;
    s_ud  = up_down;
    s_ra  = rst_adr;
    s_re  = read_en;
    s_due = dl[RD_LAT-1];
    if (!rst) begin
      m_adr  = '0;
      m_cout = 1'b0;
      m_err  = 1'b0;
      for (int i = 0; i < RD_LAT; i++) dl[i] = 1'b0;
      sb_q.delete();
    end else begin
      m_cout = s_en && !s_ra && (m_adr == (s_ud ? ADDR_W'(DEPTH-1) : ADDR_W'(0)));
      if (s_ra) m_adr = s_ud ? ADDR_W'(0) : ADDR_W'(DEPTH-1);
      else if (s_en) m_adr = s_ud ? m_adr + 1'b1 : m_adr - 1'b1;
      for (int i = RD_LAT-1; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = s_re;
      m_err = 1'b0;
      if (s_due) begin
        chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          s_e   = sb_q.pop_front();
          m_err = s_e.miss;
        end
      end
    end
    #1;
    if (rst) begin
      chk("mem_adr", 32'(mem_adr), 32'(m_adr));
      chk("c_out", 32'(c_out), 32'(m_cout));
      chk("err", 32'(err), 32'(m_err));
      if (c_out === 1'b1) cout_seen++;
    end
  end

  task automatic drive(input logic en, input logic ra, input logic ud, input logic db,
                       input logic we, input logic re, input logic cl);
    sb_t e;
    @(negedge clk);
    enable = en; rst_adr = ra; up_down = ud; data_bit = db;
    wr_en = we; read_en = re; clr = cl;
    if (re) begin
      e.a    = m_adr;
      e.miss = ((stuck[m_adr] ? {DATA_W{1'b1}} : ref_mem[m_adr]) != {DATA_W{db}});
      sb_q.push_back(e);
    end
    if (we) ref_mem[m_adr] = {DATA_W{db}};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, up_down, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_sweep(input int clr_step);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++)
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, (k == clr_step));
    idle(RD_LAT + 2);
  endtask

  task automatic chk_log(input string tag, input logic f, input logic [ADDR_W-1:0] a,
                         input logic [7:0] c);
    chk({tag, "_fail"}, 32'(fail), 32'(f));
    chk({tag, "_fail_adr"}, 32'(fail_adr), LOG ? 32'(a) : 32'd0);
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), LOG ? 32'(c) : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'hA5; ref_mem[i] = 8'hA5; stuck[i] = 1'b0;
    end
    rst = 1'b0; enable = 1'b0; up_down = 1'b1; rst_adr = 1'b0;
    data_bit = 1'b0; wr_en = 1'b0; read_en = 1'b0; clr = 1'b0;
    cout_seen = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_adr", 32'(mem_adr), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk_log("rst", 1'b0, '0, 8'd0);
    rst = 1'b1;

    // Ascending sweep: 0..15 then 0, one c_out pulse
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cout_seen = 0;
    for (int k = 0; k < DEPTH; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("asc_end_adr", 32'(mem_adr), 32'd0);
    idle(1);
    chk("asc_cout_pulses", 32'(cout_seen), 32'd1);

    // Descending sweep: load 15, 15..0 then 15
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("desc_start_adr", 32'(mem_adr), 32'd15);
    cout_seen = 0;
    for (int k = 0; k < DEPTH; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("desc_end_adr", 32'(mem_adr), 32'd15);
    chk("desc_cout_pulses", 32'(cout_seen), 32'd1);

    // Direction change mid-count does not reload the counter
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("dir_change_adr", 32'(mem_adr), 32'd2);

    // rst_adr with enable at terminal: start loaded, no c_out
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH-1; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cout_seen = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("prio_up_adr", 32'(mem_adr), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("prio_down_adr", 32'(mem_adr), 32'd15);
    chk("prio_no_cout", 32'(cout_seen), 32'd0);

    // Write background 0, then clean readback
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    read_sweep(-1);
    chk_log("clean", 1'b0, '0, 8'd0);

    // Fault injection at addresses 5 and 9
    stuck[5] = 1'b1; stuck[9] = 1'b1;
    read_sweep(-1);
    chk_log("fault", 1'b1, 4'd5, 8'd2);

    // clr coincident with the mismatch at address 9 (resolves two steps later)
    read_sweep(9 + RD_LAT);
    chk_log("clr_hit", 1'b1, 4'd9, 8'd1);

    // Reset with a mismatching read in flight
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    read_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_mem_adr", 32'(mem_adr), 32'd0);
    chk("flush_c_out", 32'(c_out), 32'd0);
    chk("flush_err", 32'(err), 32'd0);
    chk_log("flush", 1'b0, '0, 8'd0);
    rst = 1'b1;
    idle(RD_LAT + 3);
    chk_log("flush_after", 1'b0, '0, 8'd0);

    // 300 mismatches saturate the counter; first address is 15
    for (int i = 0; i < DEPTH; i++) stuck[i] = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(RD_LAT + 2);
    chk_log("sat", 1'b1, 4'd15, 8'd255);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk_log("sat_clr", 1'b0, '0, 8'd0);
    for (int i = 0; i < DEPTH; i++) stuck[i] = 1'b0;

    idle(2);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
